fourand_stim_gen: RTL and testbench
===================================

Name: fourand_stim_gen

Overview:
- Synthesizable stimulus source that sits directly upstream of the 4-input AND stage and drives its A, B, C, D inputs.
- Steps a 4-bit pattern through a full sequence at a programmable rate.
- Supports binary count, Gray count and walking-one sequences, and repeats the sequence a programmable number of times.
- Issues a per-step valid strobe so a downstream checker can sample the AND-stage outputs, and a done pulse at the end of a run.

Parameters:
- DIV_WIDTH, 16, width of the step-period input div.
- LOOP_WIDTH, 8, width of the loop-count input loops.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  level-sampled request to begin a run (honoured only in IDLE)
- stop  input  1  abort request (honoured in RUN; wins over start in IDLE)
- mode  input  2  0 = binary, 1 = Gray, 2 = walking-one, 3 = binary (reserved alias)
- div  input  DIV_WIDTH  clocks each pattern is held; 0 treated as 1
- loops  input  LOOP_WIDTH  sequence repetitions; 0 = run until stop
- A  output  1  pattern bit 3 (MSB)
- B  output  1  pattern bit 2
- C  output  1  pattern bit 1
- D  output  1  pattern bit 0 (LSB, fastest toggling)
- valid  output  1  one-cycle pulse in the first cycle each new pattern is driven
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse on normal completion

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; {A,B,C,D} = 4'b0000; valid = busy = done = 0; step counter, divider and loop counter cleared.
- All outputs are registered.
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - If start = 1 and stop = 0 at an edge: latch mode, div (0 becomes 1) and loops, then enter RUN at that same edge.
  - On that edge, drive the first pattern, with valid = 1 and busy = 1.
  - The first pattern is 4'b0000 for binary and Gray, and 4'b0001 for walking-one.
- RUN, pattern stepping:
  - Each pattern is held exactly div clocks; valid is high only in the first of them.
  - Binary: step index n = 0..15, pattern = n.
  - Gray: pattern = n ^ (n >> 1), n = 0..15.
  - Walking-one: 0001, 0010, 0100, 1000, giving 4 steps per sequence.
- RUN, sequence wrap:
  - After the last step of a sequence, the next pattern is step 0 of the next sequence, and valid pulses as usual.
  - The loop counter increments on each wrap.
- RUN, completion:
  - When the last step of sequence number loops has been held div clocks, move to DONE on the next edge.
  - On that edge: {A,B,C,D} = 0000, busy = 0, done = 1, valid = 0.
- RUN, unlimited mode: with loops = 0, the sequence wraps indefinitely; exit only via stop or reset.
- RUN, abort:
  - stop = 1 at any edge moves to IDLE at that edge.
  - On that edge: outputs 0000, busy = 0, valid = 0, done stays 0.
- RUN, ignored inputs: start is ignored in RUN. Changes to mode, div and loops during RUN have no effect until the next start.
- DONE: unconditional transition to IDLE after one cycle; done returns to 0. start during DONE is ignored.
- Latency: start edge to first pattern is 0 cycles (registered at the same edge); each further pattern follows exactly div clocks after the previous one.
- Run length: total RUN cycles = div × steps × loops, where steps = 16 or 4.
- Glitch-free requirement: only the bits that change between consecutive patterns may toggle. In Gray mode, exactly 1 bit changes per step, including the 1000 → 0000 wrap.
- Reset mid-run: outputs return to the reset values immediately, with no done pulse.

Test Plan:
- Binary, div = 1, loops = 1: start pulse → ABCD = 0000, 0001, …, 1111 on 16 consecutive cycles with valid high each cycle, then done = 1 for 1 cycle with ABCD = 0000, then IDLE.
- Binary, div = 50, loops = 1: D toggles every 50 clocks, C every 100, B every 200, A every 400 (each bit's half-period). busy is high for exactly 800 cycles. valid pulses 16 times, 50 clocks apart.
- Gray, div = 2, loops = 2: sequence 0000, 0001, 0011, 0010, 0110, … , 1000, repeated twice. Exactly one bit changes per step. busy lasts 64 cycles, then a single done pulse.
- Walking-one, div = 3, loops = 0: patterns 0001 → 0010 → 0100 → 1000 → 0001 … continue; asserting stop at cycle 20 → next edge ABCD = 0000, busy = 0, and no done pulse.
- Boundaries:
  - div = 0 behaves as div = 1.
  - start and stop high together in IDLE → stays IDLE.
  - start pulsed mid-run → no restart.
  - mode changed mid-run → sequence unaffected.
- rst_n asserted low mid-run (asynchronously, between edges) → ABCD = 0000, valid/busy/done = 0 immediately. After release, a fresh start runs normally from step 0.

Source files
------------

// File: rtl/fourand_stim_gen.sv
// Stimulus source for the 4-input AND stage: steps a 4-bit pattern (binary, Gray
// or walking-one) at a programmable rate for a programmable number of sequences.
module fourand_stim_gen #(
    parameter int unsigned DIV_WIDTH  = 16,
    parameter int unsigned LOOP_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  stop,
    input  logic [1:0]            mode,
    input  logic [DIV_WIDTH-1:0]  div,
    input  logic [LOOP_WIDTH-1:0] loops,
    output logic                  A,
    output logic                  B,
    output logic                  C,
    output logic                  D,
    output logic                  valid,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned PAT_W     = 4;
    localparam logic [1:0]  MODE_GRAY = 2'd1;
    localparam logic [1:0]  MODE_WALK = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                  state;
    logic [1:0]              mode_q;
    logic [DIV_WIDTH-1:0]    div_q;
    logic [LOOP_WIDTH-1:0]   loops_q;
    logic [DIV_WIDTH-1:0]    hold_cnt;
    logic [PAT_W-1:0]        step;
    logic [LOOP_WIDTH-1:0]   loop_cnt;
    logic [PAT_W-1:0]        abcd_q;

    logic last_hold_c;
    logic last_step_c;
    logic last_loop_c;

    // Pattern for step index n of the selected sequence; mode 3 aliases binary.
    function automatic logic [PAT_W-1:0] pattern_of(input logic [1:0] m, input logic [PAT_W-1:0] n);
        logic [PAT_W-1:0] p;
        case (m)
            MODE_GRAY: p = n ^ (n >> 1);
            MODE_WALK: p = PAT_W'(4'b0001 << n[1:0]);
            default:   p = n;
        endcase
        return p;
    endfunction

    assign last_hold_c = (hold_cnt == (div_q - DIV_WIDTH'(1)));
    assign last_step_c = (mode_q == MODE_WALK) ? (step == PAT_W'(3)) : (step == PAT_W'(15));
    // loops_q == 0 never completes: unlimited run until stop or reset.
    assign last_loop_c = (loops_q != '0) && (loop_cnt == (loops_q - LOOP_WIDTH'(1)));

    assign A = abcd_q[3];
    assign B = abcd_q[2];
    assign C = abcd_q[1];
    assign D = abcd_q[0];

    // Sequencer FSM; all outputs registered so only changing bits toggle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            mode_q   <= '0;
            div_q    <= '0;
            loops_q  <= '0;
            hold_cnt <= '0;
            step     <= '0;
            loop_cnt <= '0;
            abcd_q   <= '0;
            valid    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            valid <= 1'b0;
            done  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start && !stop) begin
                        state    <= S_RUN;
                        mode_q   <= mode;
                        div_q    <= (div == '0) ? DIV_WIDTH'(1) : div;
                        loops_q  <= loops;
                        hold_cnt <= '0;
                        step     <= '0;
                        loop_cnt <= '0;
                        abcd_q   <= pattern_of(mode, PAT_W'(0));
                        valid    <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (stop) begin
                        state  <= S_IDLE;
                        abcd_q <= '0;
                        busy   <= 1'b0;
                    end else if (!last_hold_c) begin
                        hold_cnt <= hold_cnt + DIV_WIDTH'(1);
                    end else if (last_step_c && last_loop_c) begin
                        state  <= S_DONE;
                        abcd_q <= '0;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                    end else begin
                        hold_cnt <= '0;
                        valid    <= 1'b1;
                        if (last_step_c) begin
                            step     <= '0;
                            loop_cnt <= loop_cnt + LOOP_WIDTH'(1);
                            abcd_q   <= pattern_of(mode_q, PAT_W'(0));
                        end else begin
                            step   <= step + PAT_W'(1);
                            abcd_q <= pattern_of(mode_q, step + PAT_W'(1));
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fourand_stim_gen.sv
// Scoreboard bench for fourand_stim_gen: per-cycle expected outputs are queued
// from each run description and compared one edge at a time.
module tb_fourand_stim_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        stop;
    logic [1:0]  mode;
    logic [15:0] div;
    logic [7:0]  loops;
    logic        A, B, C, D, valid, busy, done;

    fourand_stim_gen #(.DIV_WIDTH(16), .LOOP_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .mode(mode),
        .div(div), .loops(loops), .A(A), .B(B), .C(C), .D(D),
        .valid(valid), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] abcd;
        logic       valid;
        logic       busy;
        logic       done;
    } obs_t;

    typedef struct {
        string      name;
        logic [1:0] mode;
        int         div;
        int         loops;
        int         abort_at;  // RUN cycles before stop edge, 0 = none
        int         poke_at;   // record index where start/mode/div/loops are disturbed
        int         rst_at;    // record index after which rst_n drops, 0 = none
        bit         gray_chk;
    } vec_t;

    obs_t exp_q[$];
    int   checks = 0;
    int   passes = 0;
    vec_t vecs[9];

    function automatic logic [3:0] exp_pat(input logic [1:0] m, input int s);
        case (m)
            2'd1:    return 4'(s ^ (s >> 1));
            2'd2:    return 4'(1 << s);
            default: return 4'(s);
        endcase
    endfunction

    function automatic obs_t mk(input logic [3:0] p, input logic v, input logic b, input logic d);
        obs_t r;
        r.abcd = p; r.valid = v; r.busy = b; r.done = d;
        return r;
    endfunction

    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(mk(4'b0000, 1'b0, 1'b0, 1'b0));
    endtask

    task automatic push_run(input vec_t v);
        int  de    = (v.div == 0) ? 1 : v.div;
        int  steps = (v.mode == 2'd2) ? 4 : 16;
        int  nl    = (v.loops == 0) ? (v.abort_at / (de * steps) + 2) : v.loops;
        int  n     = 0;
        bit  ab    = 1'b0;
        for (int l = 0; l < nl; l++)
            for (int s = 0; s < steps; s++)
                for (int h = 0; h < de; h++) begin
                    if (v.abort_at != 0 && n == v.abort_at) ab = 1'b1;
                    if (!ab) begin
                        exp_q.push_back(mk(exp_pat(v.mode, s), h == 0, 1'b1, 1'b0));
                        n++;
                    end
                end
        if (ab) exp_q.push_back(mk(4'b0000, 1'b0, 1'b0, 1'b0));
        else    exp_q.push_back(mk(4'b0000, 1'b0, 1'b0, 1'b1));
        push_idle(1);
    endtask

    task automatic check_obs(input string name, input int idx);
        obs_t e, a;
        a = {A, B, C, D, valid, busy, done};
        checks++;
        if (exp_q.size() == 0) begin
            $display("FAIL %s rec %0d: scoreboard empty, got abcd/v/b/d=%b", name, idx, a);
        end else begin
            e = exp_q.pop_front();
            if (a === e) passes++;
            else $display("FAIL %s rec %0d: got abcd/v/b/d=%b want %b", name, idx, a, e);
        end
    endtask

    task automatic check_zero(input string name);
        obs_t a;
        a = {A, B, C, D, valid, busy, done};
        checks++;
        if (a === 7'b0) passes++;
        else $display("FAIL %s: got abcd/v/b/d=%b want 0000000", name, a);
    endtask

    task automatic run_vec(input vec_t v);
        int         idx = 0;
        logic [3:0] prev = 4'b0000;
        mode  = v.mode;
        div   = 16'(v.div);
        loops = 8'(v.loops);
        stop  = 1'b0;
        start = 1'b1;
        push_run(v);
        while (exp_q.size() > 0) begin
            @(posedge clk); #1;
            idx++;
            check_obs(v.name, idx);
            if (v.gray_chk && valid) begin
                if (idx > 1) begin
                    checks++;
                    if ($countones(prev ^ {A, B, C, D}) == 1) passes++;
                    else $display("FAIL %s gray rec %0d: %b -> %b changes %0d bits, want 1",
                                  v.name, idx, prev, {A, B, C, D}, $countones(prev ^ {A, B, C, D}));
                end
                prev = {A, B, C, D};
            end
            start = (idx == v.poke_at);
            if (idx == v.poke_at) begin
                mode  = mode + 2'd1;
                div   = div + 16'd5;
                loops = loops + 8'd2;
            end
            stop = (v.abort_at != 0 && idx == v.abort_at);
            if (v.rst_at != 0 && idx == v.rst_at) begin
                start = 1'b0;
                stop  = 1'b0;
                #2 rst_n = 1'b0;
                #1 check_zero({v.name, " async reset"});
                exp_q.delete();
                @(negedge clk);
                rst_n = 1'b1;
            end
        end
        start = 1'b0;
        stop  = 1'b0;
    endtask

    initial begin
        vecs[0] = '{"bin_d1_l1",   2'd0, 1,  1, 0,  0,  0, 1'b0};
        vecs[1] = '{"bin_d50_l1",  2'd0, 50, 1, 0,  0,  0, 1'b0};
        vecs[2] = '{"gray_d2_l2",  2'd1, 2,  2, 0,  0,  0, 1'b1};
        vecs[3] = '{"walk_d3_inf", 2'd2, 3,  0, 20, 0,  0, 1'b0};
        vecs[4] = '{"bin_d0",      2'd0, 0,  1, 0,  0,  0, 1'b0};
        vecs[5] = '{"mode3_alias", 2'd3, 1,  1, 0,  0,  0, 1'b0};
        vecs[6] = '{"walk_poke",   2'd2, 2,  2, 0,  5,  0, 1'b0};
        vecs[7] = '{"gray_poke",   2'd1, 1,  1, 0,  7,  0, 1'b1};
        vecs[8] = '{"bin_rst_mid", 2'd0, 2,  1, 0,  0,  7, 1'b0};

        rst_n = 1'b0; start = 1'b0; stop = 1'b0; mode = 2'd0; div = '0; loops = '0;
        #1 check_zero("reset_state");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // start together with stop in IDLE must not launch a run
        start = 1'b1; stop = 1'b1; mode = 2'd0; div = 16'd1; loops = 8'd1;
        push_idle(3);
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk); #1;
            check_obs("start_and_stop", i);
        end
        start = 1'b0; stop = 1'b0;

        foreach (vecs[i]) run_vec(vecs[i]);

        // fresh run after the mid-run reset starts from step 0
        run_vec('{"post_reset", 2'd0, 1, 1, 0, 0, 0, 1'b0});

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
